// File: rtl/gcd_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gcd_sched_pkg
// Purpose  : Shared types and constants for the round-robin GCD scheduler.
//            - sched_state_e : scheduler FSM states
//            - GCD_W         : default operand/result width
//            - id_t          : requester index for the default requester count
// Revision : 1.0 - initial release
// ============================================================================
package gcd_sched_pkg;

    localparam int GCD_W     = 32;
    localparam int N_REQ_DEF = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOADA = 3'd1,
        LOADB = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } sched_state_e;

    typedef logic [$clog2(N_REQ_DEF)-1:0] id_t;

endpackage : gcd_sched_pkg
`default_nettype wire

// File: rtl/gcd_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : gcd_rr_pick
// Purpose  : Combinational round-robin picker. Returns the first asserted
//            request found when searching upward from rr_ptr, wrapping at
//            N_REQ.
// Ports    : req_valid [N_REQ] in  - pending requests
//            rr_ptr    [ID_W]  in  - highest-priority index this round
//            grant_oh  [N_REQ] out - one-hot grant (all zero when none)
//            grant_idx [ID_W]  out - binary index of the grant
//            any                out - at least one request is pending
// Revision : 1.0 - initial release
// ============================================================================
module gcd_rr_pick
    import gcd_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [N_REQ-1:0] grant_oh,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any
);

    always_comb begin : p_pick
        logic [ID_W-1:0] w_idx;
        w_idx     = '0;
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        // Offset k from the pointer; modulo keeps the index in range even
        // when N_REQ is not a power of two.
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (!any && req_valid[w_idx]) begin
                any             = 1'b1;
                grant_oh[w_idx] = 1'b1;
                grant_idx       = w_idx;
            end
        end
    end

endmodule : gcd_rr_pick
`default_nettype wire

// File: rtl/gcd_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : gcd_rr_scheduler
// Purpose  : Shares one GCD engine among N_REQ requesters. A round-robin
//            grant latches the operand pair, which is sequenced into the
//            engine as loadA then loadB; the engine's done pulse produces a
//            response tagged with the requester index. One job in flight.
// Ports    : clock, reset            - single clock, sync active-high reset
//            req_valid/req_a/req_b   - request slots (slot i at [i*W +: W])
//            req_ready               - one-hot accept pulse
//            resp_valid/resp_ready   - response handshake (held until taken)
//            resp_gcd/resp_id/resp_err - response payload
//            eng_resetn/eng_opIn/eng_loadA/eng_loadB - engine drive
//            eng_outGCD/eng_outDone  - engine result
// Config   : GCD_SCHED_TIMEOUT_EN - adds a WAIT watchdog of TO_CYC cycles
//            that resets the engine and returns resp_err=1, resp_gcd=0.
// Revision : 1.0 - initial release
// ============================================================================
module gcd_rr_scheduler
    import gcd_sched_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int W      = GCD_W,
    parameter int TO_CYC = 4096
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*W-1:0]       req_a,
    input  logic [N_REQ*W-1:0]       req_b,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [W-1:0]             resp_gcd,
    output logic [$clog2(N_REQ)-1:0] resp_id,
    output logic                     resp_err,
    output logic                     eng_resetn,
    output logic [W-1:0]             eng_opIn,
    output logic                     eng_loadA,
    output logic                     eng_loadB,
    input  logic [W-1:0]             eng_outGCD,
    input  logic                     eng_outDone
);

    localparam int                c_id_w    = $clog2(N_REQ);
    localparam logic [c_id_w-1:0] c_last_id = c_id_w'(N_REQ - 1);

    sched_state_e       state_q,      state_d;
    logic [c_id_w-1:0]  rr_ptr_q,     rr_ptr_d;
    logic [c_id_w-1:0]  id_q,         id_d;
    logic [W-1:0]       op_a_q,       op_a_d;
    logic [W-1:0]       op_b_q,       op_b_d;
    logic [N_REQ-1:0]   req_ready_q,  req_ready_d;
    logic               resp_valid_q, resp_valid_d;
    logic [W-1:0]       resp_gcd_q,   resp_gcd_d;
    logic [W-1:0]       eng_opIn_q,   eng_opIn_d;
    logic               eng_loadA_q,  eng_loadA_d;
    logic               eng_loadB_q,  eng_loadB_d;
    logic               eng_resetn_q, eng_resetn_d;

    logic [N_REQ-1:0]   w_grant_oh;
    logic [c_id_w-1:0]  w_grant_idx;
    logic               w_any;

`ifdef GCD_SCHED_TIMEOUT_EN
    localparam int                c_cnt_w   = $clog2(TO_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'(TO_CYC - 1);

    logic [c_cnt_w-1:0] to_cnt_q,   to_cnt_d;
    logic               resp_err_q, resp_err_d;
`else
    localparam int c_unused_to_cyc = TO_CYC;
`endif

    gcd_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (c_id_w)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant_oh  (w_grant_oh),
        .grant_idx (w_grant_idx),
        .any       (w_any)
    );

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        id_d         = id_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        req_ready_d  = '0;
        resp_valid_d = resp_valid_q;
        resp_gcd_d   = resp_gcd_q;
        eng_opIn_d   = eng_opIn_q;
        eng_loadA_d  = 1'b0;
        eng_loadB_d  = 1'b0;
        eng_resetn_d = 1'b1;
`ifdef GCD_SCHED_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
        resp_err_d   = resp_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_any) begin
                    req_ready_d = w_grant_oh;
                    id_d        = w_grant_idx;
                    op_a_d      = req_a[w_grant_idx*W +: W];
                    op_b_d      = req_b[w_grant_idx*W +: W];
                    // Next round starts just past the winner.
                    rr_ptr_d    = (w_grant_idx == c_last_id) ? '0 : w_grant_idx + 1'b1;
                    state_d     = LOADA;
                end
            end
            LOADA: begin
                eng_opIn_d  = op_a_q;
                eng_loadA_d = 1'b1;
                state_d     = LOADB;
            end
            LOADB: begin
                eng_opIn_d  = op_b_q;
                eng_loadB_d = 1'b1;
`ifdef GCD_SCHED_TIMEOUT_EN
                to_cnt_d    = '0;
`endif
                state_d     = WAIT;
            end
            WAIT: begin
                if (eng_outDone) begin
                    resp_gcd_d   = eng_outGCD;
                    resp_valid_d = 1'b1;
`ifdef GCD_SCHED_TIMEOUT_EN
                    resp_err_d   = 1'b0;
`endif
                    state_d      = RESP;
                end
`ifdef GCD_SCHED_TIMEOUT_EN
                else if (to_cnt_q == c_to_last) begin
                    // Engine is hung: kick it and report an errored result.
                    eng_resetn_d = 1'b0;
                    resp_gcd_d   = '0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            req_ready_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_gcd_q   <= '0;
            eng_opIn_q   <= '0;
            eng_loadA_q  <= 1'b0;
            eng_loadB_q  <= 1'b0;
            eng_resetn_q <= 1'b0;
`ifdef GCD_SCHED_TIMEOUT_EN
            to_cnt_q     <= '0;
            resp_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_gcd_q   <= resp_gcd_d;
            eng_opIn_q   <= eng_opIn_d;
            eng_loadA_q  <= eng_loadA_d;
            eng_loadB_q  <= eng_loadB_d;
            eng_resetn_q <= eng_resetn_d;
`ifdef GCD_SCHED_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
            resp_err_q   <= resp_err_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_gcd   = resp_gcd_q;
    assign resp_id    = id_q;
    assign eng_resetn = eng_resetn_q;
    assign eng_opIn   = eng_opIn_q;
    assign eng_loadA  = eng_loadA_q;
    assign eng_loadB  = eng_loadB_q;
`ifdef GCD_SCHED_TIMEOUT_EN
    assign resp_err   = resp_err_q;
`else
    assign resp_err   = 1'b0;
`endif

endmodule : gcd_rr_scheduler
`default_nettype wire

// File: tb/tb_gcd_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_rr_scheduler
// Purpose  : Self-checking bench for gcd_rr_scheduler. Requesters, a
//            behavioural GCD engine and a response consumer are modelled
//            here; a reference model (round-robin pick over pending slots,
//            Euclid GCD, FIFO of expected responses) predicts every grant,
//            load strobe and response. GCD_SCHED_TIMEOUT_EN adds a hung-
//            engine scenario with TO_CYC=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_rr_scheduler;
    import gcd_sched_pkg::*;

    localparam int N  = 4;
    localparam int W  = GCD_W;
    localparam int TO = 16;

    typedef struct packed {
        logic [7:0]   id;
        logic [W-1:0] g;
        logic         err;
    } exp_t;

    logic           clock;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           resp_valid;
    logic           resp_ready;
    logic [W-1:0]   resp_gcd;
    id_t            resp_id;
    logic           resp_err;
    logic           eng_resetn;
    logic [W-1:0]   eng_opIn;
    logic           eng_loadA;
    logic           eng_loadB;
    logic [W-1:0]   eng_outGCD;
    logic           eng_outDone;

    gcd_rr_scheduler #(
        .N_REQ  (N),
        .W      (W),
        .TO_CYC (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_gcd    (resp_gcd),
        .resp_id     (resp_id),
        .resp_err    (resp_err),
        .eng_resetn  (eng_resetn),
        .eng_opIn    (eng_opIn),
        .eng_loadA   (eng_loadA),
        .eng_loadB   (eng_loadB),
        .eng_outGCD  (eng_outGCD),
        .eng_outDone (eng_outDone)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model state
    exp_t         exp_q[$];
    int           grant_log[$];
    logic [W-1:0] resp_log[$];
    int           rid_log[$];
    int           tb_ptr = 0;
    bit           job_busy = 0;
    bit           free_pending = 0;
    int           phase = 0;
    logic [W-1:0] cur_a, cur_b;
    logic [N-1:0] drop_mask = '0;
    // Engine model
    bit           eng_busy = 0;
    bit           eng_dead = 0;
    int           eng_cnt = 0;
    logic [W-1:0] eng_a, eng_b;
    int           resetn_low_cnt = 0;
    bit           spurious_en = 0;
    // Consumer model
    bit           rand_bp = 0;
    bit           prev_rv = 0;
    int           hold_req = 0;
    int           hold_cnt = 0;
    int           stall_cycles = 0;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int ref_steps(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] t;
        int n = 0;
        while (b != 0 && n < 20) begin
            t = a % b;
            a = b;
            b = t;
            n++;
        end
        return n;
    endfunction

    function automatic int ref_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'd1;
            2, 3:    return W'($urandom_range(1, 1000));
            4:       return 32'hFFFF_FFFF - W'($urandom_range(0, 3));
            default: return W'($urandom);
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic post(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_valid[i]    = 1'b1;
    endtask

    // One clock: sample DUT outputs, compare with the model, then drive the
    // requesters, engine and consumer for the next edge.
    task automatic tick();
        int           g;
        logic [N-1:0] exp_rdy;
        exp_t         e;
        @(posedge clock);
        #1;
        // Operand sequencing after a grant
        check("eng_loadA", eng_loadA, phase == 1);
        check("eng_loadB", eng_loadB, phase == 2);
        if (phase == 1) begin
            check("opIn_A", eng_opIn, cur_a);
            phase = 2;
        end else if (phase == 2) begin
            check("opIn_B", eng_opIn, cur_b);
            phase = 0;
        end
        // Arbitration: decision at the last edge used the slots held then
        g       = job_busy ? -1 : ref_pick(req_valid, tb_ptr);
        exp_rdy = '0;
        if (g >= 0) exp_rdy = N'(1) << g;
        check("req_ready", req_ready, exp_rdy);
        for (int i = 0; i < N; i++) if (req_ready[i]) grant_log.push_back(i);
        if (g >= 0) begin
            job_busy = 1;
            tb_ptr   = (g + 1) % N;
            cur_a    = req_a[g*W +: W];
            cur_b    = req_b[g*W +: W];
            phase    = 1;
            e.id     = 8'(g);
            e.err    = eng_dead;
            e.g      = eng_dead ? '0 : ref_gcd(cur_a, cur_b);
            exp_q.push_back(e);
        end
        if (free_pending) begin
            job_busy     = 0;
            free_pending = 0;
        end
        // Requesters hold valid through the accept cycle, then drop
        req_valid = req_valid & ~drop_mask;
        drop_mask = req_ready;
        // Engine
        eng_outDone = 1'b0;
        if (!eng_resetn) begin
            eng_busy = 0;
            resetn_low_cnt++;
        end else if (eng_loadA) begin
            eng_a = eng_opIn;
        end else if (eng_loadB) begin
            eng_b    = eng_opIn;
            eng_busy = !eng_dead;
            eng_cnt  = 2 + ref_steps(eng_a, eng_b);
        end else if (eng_busy) begin
            eng_cnt--;
            if (eng_cnt <= 0) begin
                eng_outDone = 1'b1;
                eng_outGCD  = ref_gcd(eng_a, eng_b);
                eng_busy    = 0;
            end
        end else if (spurious_en && !job_busy && $urandom_range(0, 7) == 0) begin
            eng_outDone = 1'b1;
            eng_outGCD  = W'($urandom);
        end
        // Consumer
        if (resp_valid) begin
            if (!prev_rv) hold_cnt = hold_req;
            if (exp_q.size() == 0) begin
                check("resp_unexpected", resp_valid, 1'b0);
                resp_ready = 1'b1;
            end else begin
                check("resp_id",  resp_id,  exp_q[0].id);
                check("resp_gcd", resp_gcd, exp_q[0].g);
                check("resp_err", resp_err, exp_q[0].err);
                if (hold_cnt > 0) begin
                    hold_cnt--;
                    resp_ready = 1'b0;
                    stall_cycles++;
                end else begin
                    resp_ready = rand_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
                if (resp_ready) begin
                    resp_log.push_back(resp_gcd);
                    rid_log.push_back(int'(resp_id));
                    void'(exp_q.pop_front());
                    free_pending = 1;
                end
            end
        end else begin
            resp_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        prev_rv = resp_valid;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        req_valid   = '0;
        drop_mask   = '0;
        resp_ready  = 1'b0;
        eng_outDone = 1'b0;
        @(posedge clock);
        #1;
        check("rst_req_ready",  req_ready,  '0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_gcd",   resp_gcd,   '0);
        check("rst_resp_id",    resp_id,    '0);
        check("rst_resp_err",   resp_err,   1'b0);
        check("rst_loadA",      eng_loadA,  1'b0);
        check("rst_loadB",      eng_loadB,  1'b0);
        check("rst_opIn",       eng_opIn,   '0);
        check("rst_eng_resetn", eng_resetn, 1'b0);
        reset        = 1'b0;
        exp_q.delete();
        job_busy     = 0;
        free_pending = 0;
        phase        = 0;
        tb_ptr       = 0;
        eng_busy     = 0;
        prev_rv      = 0;
        hold_cnt     = 0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((req_valid != '0 || drop_mask != '0 || job_busy || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_in_budget", n < budget, 1'b1);
    endtask

    logic [W-1:0] ba[5]   = '{32'd0, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [W-1:0] bb[5]   = '{32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'h4000_0000};
    logic [W-1:0] bexp[5] = '{32'd7, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'h4000_0000};

    initial begin
        int n;
        reset       = 1'b1;
        req_valid   = '0;
        req_a       = '0;
        req_b       = '0;
        resp_ready  = 1'b0;
        eng_outGCD  = '0;
        eng_outDone = 1'b0;
        do_reset();

        // Single request
        grant_log.delete();
        resp_log.delete();
        post(0, 32'd48, 32'd18);
        drain(200);
        check("single_grants", grant_log.size(), 1);
        check("single_slot",   grant_log[0], 0);
        check("single_gcd",    resp_log[0], 6);

        // Contention from reset: all four, then slots 0 and 2
        do_reset();
        grant_log.delete();
        for (int i = 0; i < N; i++) post(i, W'((i + 1) * 30), W'((i + 1) * 12));
        drain(400);
        check("cont_grants", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) check("cont_order", grant_log[i], i);
        grant_log.delete();
        post(0, 32'd9, 32'd6);
        post(2, 32'd14, 32'd21);
        drain(400);
        check("cont2_grants", grant_log.size(), 2);
        check("cont2_first",  grant_log[0], 0);
        check("cont2_second", grant_log[1], 2);

        // Back-pressure with a competing request waiting
        grant_log.delete();
        resp_log.delete();
        hold_req     = 10;
        stall_cycles = 0;
        post(1, 32'd1071, 32'd462);
        repeat (3) tick();
        post(3, 32'd35, 32'd14);
        drain(400);
        hold_req = 0;
        check("bp_stall_cycles", stall_cycles, 20);
        check("bp_gcd",          resp_log[0], 21);
        check("bp_order0",       grant_log[0], 1);
        check("bp_order1",       grant_log[1], 3);

        // Boundary operands
        for (int k = 0; k < 5; k++) begin
            resp_log.delete();
            post(k % N, ba[k], bb[k]);
            drain(400);
            check("boundary_gcd", resp_log[0], bexp[k]);
        end

        // Reset while waiting on the engine
        resp_log.delete();
        post(2, 32'd100, 32'd75);
        n = 0;
        while (!(eng_busy && job_busy) && n < 50) begin
            tick();
            n++;
        end
        check("reached_wait", eng_busy, 1'b1);
        tick();
        do_reset();
        resp_log.delete();
        rid_log.delete();
        post(1, 32'd12, 32'd8);
        drain(200);
        check("post_rst_count", resp_log.size(), 1);
        check("post_rst_gcd",   resp_log[0], 4);
        check("post_rst_id",    rid_log[0], 1);

        // Randomized traffic with back-pressure and stray done pulses
        rand_bp     = 1;
        spurious_en = 1;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                int i;
                i = $urandom_range(0, N - 1);
                if (!req_valid[i] && !drop_mask[i]) post(i, rnd_op(), rnd_op());
            end
            tick();
        end
        rand_bp     = 0;
        spurious_en = 0;
        drain(3000);

`ifdef GCD_SCHED_TIMEOUT_EN
        // Hung engine: watchdog must kick it once and return an error
        resp_log.delete();
        eng_dead       = 1;
        resetn_low_cnt = 0;
        post(0, 32'd9, 32'd6);
        drain(400);
        eng_dead = 0;
        check("to_resetn_pulses", resetn_low_cnt, 1);
        check("to_gcd",           resp_log[0], 0);
        resp_log.delete();
        post(2, 32'd9, 32'd6);
        drain(400);
        check("to_recover_gcd",   resp_log[0], 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "simulation did not finish");
    end

endmodule : tb_gcd_rr_scheduler
`default_nettype wire
